// File: rtl/fib_arbiter_if.sv
// Request/response bundle between two clients and the shared Fibonacci engine.
// The master side is the client pair, the slave side is the arbiter.
interface fib_arbiter_if #(
    parameter int N_W   = 4,
    parameter int RES_W = 16
);
    logic             req0_valid;
    logic [N_W-1:0]   req0_n;
    logic             req0_ready;
    logic             req1_valid;
    logic [N_W-1:0]   req1_n;
    logic             req1_ready;
    logic             resp_valid;
    logic             resp_id;
    logic [RES_W-1:0] resp_result;
    logic             resp_ovf;
    logic             busy;

    modport master (
        output req0_valid, req0_n, req1_valid, req1_n,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_ovf, busy
    );

    modport slave (
        input  req0_valid, req0_n, req1_valid, req1_n,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_ovf, busy
    );
endinterface

// File: rtl/fib_arbiter.sv
// Round-robin arbiter in front of one iterative Fibonacci engine shared by two requesters.
// fib(0)=fib(1)=fib(2)=1; results are mod 2^RES_W with a sticky carry-out flag.
module fib_arbiter #(
    parameter int N_W   = 4,
    parameter int RES_W = 16
) (
    input logic         clk,
    input logic         rst,
    fib_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic             last_grant;
    logic             grant_vld, grant_id, accept, run_end;
    logic [N_W-1:0]   n_r;
    logic             id_r;
    logic [N_W:0]     i;
    logic [RES_W-1:0] a, b;
    logic             ovf;
    logic [RES_W-1:0] res_q;
    logic             id_q, ovf_q;
    logic [RES_W:0]   sum;

    function automatic logic [RES_W:0] fib_add(input logic [RES_W-1:0] x, input logic [RES_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid & bus.req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = bus.req1_valid;
    end

    assign accept  = (state == IDLE) & grant_vld;
    // i is one bit wider than n so that i > n always terminates, even for n = 2^N_W-1.
    assign run_end = (i > {1'b0, n_r});
    assign sum     = fib_add(a, b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            res_q      <= '0;
            id_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                n_r        <= grant_id ? bus.req1_n : bus.req0_n;
                id_r       <= grant_id;
                last_grant <= grant_id;
                a          <= RES_W'(1);
                b          <= RES_W'(1);
                i          <= (N_W+1)'(3);
                ovf        <= 1'b0;
            end
            if (state == RUN) begin
                if (run_end) begin
                    res_q <= b;
                    id_q  <= id_r;
                    ovf_q <= ovf;
                end else begin
                    a   <= b;
                    b   <= sum[RES_W-1:0];
                    i   <= i + 1'b1;
                    ovf <= ovf | sum[RES_W];
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (run_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = accept & ~grant_id;
        bus.req1_ready = accept & grant_id;
        bus.resp_valid = (state == DONE);
        bus.busy       = (state != IDLE);
    end

    assign bus.resp_result = res_q;
    assign bus.resp_id     = id_q;
    assign bus.resp_ovf    = ovf_q;
endmodule

// File: tb/tb_fib_arbiter.sv
// Directed bench for fib_arbiter: a 16-bit instance for arbitration and results, an 8-bit one for overflow.
module tb_fib_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nfail = 0;
    bit   both_ready_seen = 1'b0;

    always #5 clk = ~clk;

    fib_arbiter_if #(.N_W(4), .RES_W(16)) b();
    fib_arbiter_if #(.N_W(4), .RES_W(8))  b8();

    fib_arbiter #(.N_W(4), .RES_W(16)) dut  (.clk(clk), .rst(rst), .bus(b.slave));
    fib_arbiter #(.N_W(4), .RES_W(8))  dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

    always @(negedge clk)
        if (b.req0_ready && b.req1_ready) both_ready_seen = 1'b1;

    task automatic wait_resp(input bit sel, output int cyc, output bit found);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (sel ? b8.resp_valid : b.resp_valid) found = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if (b.busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got=%b exp=0", b.busy); end
        nvec++; if (b.resp_valid !== 1'b0) begin nfail++; $display("FAIL rst_resp_valid got=%b exp=0", b.resp_valid); end
        nvec++; if (b.resp_result !== 16'd0) begin nfail++; $display("FAIL rst_result got=%0d exp=0", b.resp_result); end
        nvec++; if (b.resp_id !== 1'b0) begin nfail++; $display("FAIL rst_id got=%b exp=0", b.resp_id); end
        nvec++; if (b.resp_ovf !== 1'b0) begin nfail++; $display("FAIL rst_ovf got=%b exp=0", b.resp_ovf); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cyc; bit found;
        b.req0_valid = 1'b1; b.req0_n = 4'd10;
        #1;
        nvec++; if (b.req0_ready !== 1'b1) begin nfail++; $display("FAIL single_ready0 got=%b exp=1", b.req0_ready); end
        nvec++; if (b.req1_ready !== 1'b0) begin nfail++; $display("FAIL single_ready1 got=%b exp=0", b.req1_ready); end
        @(posedge clk); #1;
        b.req0_valid = 1'b0;
        nvec++; if (b.busy !== 1'b1) begin nfail++; $display("FAIL single_busy got=%b exp=1", b.busy); end
        wait_resp(1'b0, cyc, found);
        nvec++; if (!found || cyc != 9) begin nfail++; $display("FAIL single_latency got=%0d found=%b exp=9", cyc, found); end
        nvec++; if (b.resp_id !== 1'b0) begin nfail++; $display("FAIL single_id got=%b exp=0", b.resp_id); end
        nvec++; if (b.resp_result !== 16'd55) begin nfail++; $display("FAIL single_result got=%0d exp=55", b.resp_result); end
        nvec++; if (b.resp_ovf !== 1'b0) begin nfail++; $display("FAIL single_ovf got=%b exp=0", b.resp_ovf); end
        @(negedge clk);
        nvec++; if (b.resp_valid !== 1'b0) begin nfail++; $display("FAIL single_pulse_width got=%b exp=0", b.resp_valid); end
        nvec++; if (b.busy !== 1'b0) begin nfail++; $display("FAIL single_idle_busy got=%b exp=0", b.busy); end
        nvec++; if (b.resp_result !== 16'd55) begin nfail++; $display("FAIL single_hold got=%0d exp=55", b.resp_result); end
    endtask

    task automatic test_both();
        int cyc; bit found;
        apply_reset();
        both_ready_seen = 1'b0;
        b.req0_valid = 1'b1; b.req0_n = 4'd15;
        b.req1_valid = 1'b1; b.req1_n = 4'd5;
        #1;
        nvec++; if (b.req0_ready !== 1'b1) begin nfail++; $display("FAIL both_first_ready0 got=%b exp=1", b.req0_ready); end
        @(posedge clk); #1;
        b.req0_valid = 1'b0;
        nvec++; if (b.req1_ready !== 1'b0) begin nfail++; $display("FAIL both_ready1_in_run got=%b exp=0", b.req1_ready); end
        wait_resp(1'b0, cyc, found);
        nvec++; if (!found || cyc != 14) begin nfail++; $display("FAIL both_latency0 got=%0d found=%b exp=14", cyc, found); end
        nvec++; if (b.resp_id !== 1'b0) begin nfail++; $display("FAIL both_id0 got=%b exp=0", b.resp_id); end
        nvec++; if (b.resp_result !== 16'd610) begin nfail++; $display("FAIL both_result0 got=%0d exp=610", b.resp_result); end
        nvec++; if (b.resp_ovf !== 1'b0) begin nfail++; $display("FAIL both_ovf0 got=%b exp=0", b.resp_ovf); end
        @(negedge clk); #1;
        nvec++; if (b.req1_ready !== 1'b1) begin nfail++; $display("FAIL both_second_ready1 got=%b exp=1", b.req1_ready); end
        @(posedge clk); #1;
        b.req1_valid = 1'b0;
        wait_resp(1'b0, cyc, found);
        nvec++; if (!found || cyc != 4) begin nfail++; $display("FAIL both_latency1 got=%0d found=%b exp=4", cyc, found); end
        nvec++; if (b.resp_id !== 1'b1) begin nfail++; $display("FAIL both_id1 got=%b exp=1", b.resp_id); end
        nvec++; if (b.resp_result !== 16'd5) begin nfail++; $display("FAIL both_result1 got=%0d exp=5", b.resp_result); end
        nvec++; if (both_ready_seen !== 1'b0) begin nfail++; $display("FAIL both_ready_overlap got=%b exp=0", both_ready_seen); end
    endtask

    task automatic test_alternate();
        int cyc; bit found;
        bit exp_id;
        logic [15:0] exp_res;
        int exp_cyc;
        apply_reset();
        both_ready_seen = 1'b0;
        b.req0_valid = 1'b1; b.req0_n = 4'd6;
        b.req1_valid = 1'b1; b.req1_n = 4'd3;
        for (int k = 0; k < 4; k++) begin
            exp_id  = k[0];
            exp_res = exp_id ? 16'd2 : 16'd8;
            exp_cyc = exp_id ? 2 : 5;
            #1;
            nvec++; if (b.resp_valid !== 1'b0) begin nfail++; $display("FAIL alt%0d_no_extra_resp got=%b exp=0", k, b.resp_valid); end
            nvec++; if (b.req0_ready !== !exp_id) begin nfail++; $display("FAIL alt%0d_ready0 got=%b exp=%b", k, b.req0_ready, !exp_id); end
            nvec++; if (b.req1_ready !== exp_id) begin nfail++; $display("FAIL alt%0d_ready1 got=%b exp=%b", k, b.req1_ready, exp_id); end
            @(posedge clk); #1;
            if (!exp_id) b.req0_valid = 1'b0;
            wait_resp(1'b0, cyc, found);
            nvec++; if (!found || cyc != exp_cyc) begin nfail++; $display("FAIL alt%0d_latency got=%0d found=%b exp=%0d", k, cyc, found, exp_cyc); end
            nvec++; if (b.resp_id !== exp_id) begin nfail++; $display("FAIL alt%0d_id got=%b exp=%b", k, b.resp_id, exp_id); end
            nvec++; if (b.resp_result !== exp_res) begin nfail++; $display("FAIL alt%0d_result got=%0d exp=%0d", k, b.resp_result, exp_res); end
            b.req0_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b0;
        nvec++; if (both_ready_seen !== 1'b0) begin nfail++; $display("FAIL alt_ready_overlap got=%b exp=0", both_ready_seen); end
    endtask

    task automatic test_small_n();
        int cyc; bit found;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            b.req1_valid = 1'b1; b.req1_n = 4'(k);
            #1;
            nvec++; if (b.req1_ready !== 1'b1) begin nfail++; $display("FAIL small%0d_ready1 got=%b exp=1", k, b.req1_ready); end
            @(posedge clk); #1;
            b.req1_valid = 1'b0;
            wait_resp(1'b0, cyc, found);
            nvec++; if (!found || cyc != 1) begin nfail++; $display("FAIL small%0d_latency got=%0d found=%b exp=1", k, cyc, found); end
            nvec++; if (b.resp_result !== 16'd1) begin nfail++; $display("FAIL small%0d_result got=%0d exp=1", k, b.resp_result); end
            nvec++; if (b.resp_id !== 1'b1) begin nfail++; $display("FAIL small%0d_id got=%b exp=1", k, b.resp_id); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_run();
        int cyc; bit found;
        b.req0_valid = 1'b1; b.req0_n = 4'd15;
        @(posedge clk); #1;
        b.req0_valid = 1'b0;
        repeat (5) @(negedge clk);
        nvec++; if (b.busy !== 1'b1) begin nfail++; $display("FAIL rrun_busy_before got=%b exp=1", b.busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        nvec++; if (b.busy !== 1'b0) begin nfail++; $display("FAIL rrun_busy got=%b exp=0", b.busy); end
        nvec++; if (b.resp_valid !== 1'b0) begin nfail++; $display("FAIL rrun_resp_valid got=%b exp=0", b.resp_valid); end
        nvec++; if (b.resp_result !== 16'd0) begin nfail++; $display("FAIL rrun_result got=%0d exp=0", b.resp_result); end
        nvec++; if (b.resp_id !== 1'b0) begin nfail++; $display("FAIL rrun_id got=%b exp=0", b.resp_id); end
        @(negedge clk);
        rst = 1'b0;
        b.req1_valid = 1'b1; b.req1_n = 4'd4;
        #1;
        nvec++; if (b.req1_ready !== 1'b1) begin nfail++; $display("FAIL rrun_ready1 got=%b exp=1", b.req1_ready); end
        @(posedge clk); #1;
        b.req1_valid = 1'b0;
        wait_resp(1'b0, cyc, found);
        nvec++; if (!found || cyc != 3) begin nfail++; $display("FAIL rrun_latency got=%0d found=%b exp=3", cyc, found); end
        nvec++; if (b.resp_result !== 16'd3) begin nfail++; $display("FAIL rrun_result_after got=%0d exp=3", b.resp_result); end
        nvec++; if (b.resp_id !== 1'b1) begin nfail++; $display("FAIL rrun_id_after got=%b exp=1", b.resp_id); end
    endtask

    task automatic test_overflow();
        int cyc; bit found;
        @(negedge clk);
        b8.req0_valid = 1'b1; b8.req0_n = 4'd14;
        #1;
        nvec++; if (b8.req0_ready !== 1'b1) begin nfail++; $display("FAIL ovf_ready0 got=%b exp=1", b8.req0_ready); end
        @(posedge clk); #1;
        b8.req0_valid = 1'b0;
        wait_resp(1'b1, cyc, found);
        nvec++; if (!found || cyc != 13) begin nfail++; $display("FAIL ovf_latency got=%0d found=%b exp=13", cyc, found); end
        nvec++; if (b8.resp_result !== 8'd121) begin nfail++; $display("FAIL ovf_result got=%0d exp=121", b8.resp_result); end
        nvec++; if (b8.resp_ovf !== 1'b1) begin nfail++; $display("FAIL ovf_flag got=%b exp=1", b8.resp_ovf); end
        nvec++; if (b8.resp_id !== 1'b0) begin nfail++; $display("FAIL ovf_id got=%b exp=0", b8.resp_id); end
    endtask

    initial begin
        b.req0_valid = 1'b0; b.req0_n = '0; b.req1_valid = 1'b0; b.req1_n = '0;
        b8.req0_valid = 1'b0; b8.req0_n = '0; b8.req1_valid = 1'b0; b8.req1_n = '0;
        test_reset();
        test_single();
        test_both();
        test_alternate();
        test_small_n();
        test_reset_run();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fib_arbiter.md
Name: fib_arbiter

Overview:
- Shares one iterative Fibonacci engine between two requesters (port 0, port 1).
- Round-robin arbitration, valid/ready request handshake, one-cycle response pulse tagged with requester id.
- Sits between client blocks and the sequential Fibonacci datapath. It is the sequenced, multi-cycle replacement for the purely combinational fibonacci function block.
- Numeric convention matches that block: fib(0)=fib(1)=fib(2)=1, fib(n)=fib(n-1)+fib(n-2) for n>2.

Parameters:
N_W, 4, width of the index n.
RES_W, 16, width of the result and of the internal a/b registers.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has a job. Held, with req0_n stable, until accepted.
req0_n  input  N_W  requester 0 index.
req0_ready  output  1  requester 0 job accepted this cycle (valid & ready at clk edge).
req1_valid  input  1  requester 1 has a job. Same hold rule as requester 0.
req1_n  input  N_W  requester 1 index.
req1_ready  output  1  requester 1 job accepted this cycle.
resp_valid  output  1  one-cycle pulse: result is valid.
resp_id  output  1  requester that owns the result.
resp_result  output  RES_W  fib(n) mod 2^RES_W.
resp_ovf  output  1  a sum exceeded RES_W bits during this job.
busy  output  1  engine not IDLE.

Behaviour:
- Reset (sync, priority over everything):
  - state=IDLE; resp_valid=0, resp_id=0, resp_result=0, resp_ovf=0, busy=0.
  - last_grant=1, so port 0 wins the first tie.
  - Any job in flight is dropped with no response.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant combinational. Only one valid: that port. Both valid: the port != last_grant. None: no grant.
  - reqX_ready = (state==IDLE) & grant==X. Never both high. Both low outside IDLE.
  - On an accept edge:
    - capture n_r=reqX_n and id_r=X; set last_grant=X.
    - a=1, b=1, i=3, ovf=0.
    - go to RUN.
- RUN, each cycle:
  - If i>n_r (width N_W+1 for i, so i never wraps): go to DONE; resp_result<=b, resp_id<=id_r, resp_ovf<=ovf.
  - Else: b<=a+b, a<=b, i<=i+1; ovf set if the RES_W+1-bit sum carries out.
- DONE:
  - resp_valid=1 for exactly this one cycle.
  - Next state is IDLE unconditionally. No response backpressure.
- Outputs between pulses:
  - resp_result/resp_id/resp_ovf hold their last values until the next DONE.
  - resp_valid is 0 in IDLE and RUN.
- Latency:
  - Accept edge to DONE entry = max(n-2,0)+1 cycles.
  - resp_valid is high in the cycle following that edge.
  - n=15: accept edge to DONE entry = 14 cycles.
- Throughput:
  - The next accept can occur in the IDLE cycle after DONE.
  - Back-to-back jobs are separated by one DONE cycle and one IDLE/accept cycle.
- busy = 1 in RUN and DONE.
- Inputs are ignored outside the IDLE accept cycle. A non-granted requester keeps waiting; the arbiter never drops it.
- A requester whose valid is high in IDLE is granted within two jobs (round-robin fairness).
- n=0,1,2 take the same path: one RUN cycle, result 1.

Test Plan:
- Reset, then req0_valid=1, n=10 -> req0_ready high in the first IDLE cycle; resp_valid pulses 9 cycles after the accept edge, with resp_id=0, resp_result=55, resp_ovf=0.
- Both valid, req0_n=15, req1_n=5, continuously -> port 0 served first (610, id 0), then port 1 (5, id 1). The ready signals are never high together.
- req1 held valid continuously with n=3, and req0 re-asserted after each response -> grants alternate 0,1,0,1. Each job is answered exactly once with its own id.
- n=0, n=1, n=2 on port 1 -> result 1 each time, with one RUN cycle each.
- Assert rst during RUN for n=15 -> next cycle busy=0 and all outputs 0; no resp_valid. A following req1 n=4 -> 3.
- RES_W=8 override, n=14 (fib=377) -> resp_result=377 mod 256=121, resp_ovf=1.
